// File: rtl/el2_trace_buf_pkg.sv
// Shared types for the multi-lane retire trace capture buffer.
// The packet layout matches the single-lane el2 retire trace port (104 bits).
package el2_trace_buf_pkg;

    typedef struct packed {
        logic [31:0] trace_rv_i_insn_ip;
        logic [31:0] trace_rv_i_address_ip;
        logic        trace_rv_i_valid_ip;
        logic        trace_rv_i_exception_ip;
        logic [4:0]  trace_rv_i_ecause_ip;
        logic        trace_rv_i_interrupt_ip;
        logic [31:0] trace_rv_i_tval_ip;
    } el2_trace_pkt_t;

    // Capture filter: everything, exceptions/interrupts only, or nothing.
    typedef enum logic [1:0] {
        TR_ALL  = 2'b00,
        TR_EXC  = 2'b01,
        TR_OFF0 = 2'b10,
        TR_OFF1 = 2'b11
    } el2_trace_mode_t;

    // One FIFO slot: the packet plus a flag saying packets were lost just before it.
    typedef struct packed {
        logic           gap;
        el2_trace_pkt_t pkt;
    } el2_trace_entry_t;

    // A lane is worth storing when it is valid and passes the current filter.
    function automatic logic lane_is_candidate(input el2_trace_pkt_t p, input el2_trace_mode_t m);
        return p.trace_rv_i_valid_ip &&
               ((m == TR_ALL) ||
                ((m == TR_EXC) && (p.trace_rv_i_exception_ip || p.trace_rv_i_interrupt_ip)));
    endfunction

endpackage

// File: rtl/el2_trace_buf_if.sv
// Bundle of the trace capture buffer's lane inputs, controls and drain port.
// master = the core/sink side driving it, slave = the buffer itself.
interface el2_trace_buf_if #(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
);
    import el2_trace_buf_pkg::*;

    localparam int CNT_BITS = $clog2(DEPTH) + 1;

    el2_trace_pkt_t [NUM_CH-1:0] trace_in;
    el2_trace_mode_t             tr_mode;
    logic                        tr_flush;
    logic                        tr_lost_clr;
    logic                        tr_out_valid;
    logic                        tr_out_ready;
    el2_trace_pkt_t              tr_out_pkt;
    logic                        tr_out_gap;
    logic [CNT_BITS-1:0]         tr_count;
    logic                        tr_full;
    logic [CNT_W-1:0]            tr_lost_cnt;

    modport master (
        output trace_in, tr_mode, tr_flush, tr_lost_clr, tr_out_ready,
        input  tr_out_valid, tr_out_pkt, tr_out_gap, tr_count, tr_full, tr_lost_cnt
    );

    modport slave (
        input  trace_in, tr_mode, tr_flush, tr_lost_clr, tr_out_ready,
        output tr_out_valid, tr_out_pkt, tr_out_gap, tr_count, tr_full, tr_lost_cnt
    );

endinterface

// File: rtl/el2_trace_lane_sel.sv
// Picks which candidate lanes fit into the free FIFO space. Older lanes win,
// so accepted lanes always form a prefix of the candidates and every
// dropped lane is younger than every accepted one.
module el2_trace_lane_sel #(
    parameter  int NUM_CH   = 2,
    parameter  int DEPTH    = 16,
    localparam int CNT_BITS = $clog2(DEPTH) + 1,
    localparam int CW       = $clog2(NUM_CH + 1)
) (
    input  logic [NUM_CH-1:0]         cand,
    input  logic [CNT_BITS-1:0]       free,
    output logic [NUM_CH-1:0]         accept,
    output logic [NUM_CH-1:0][CW-1:0] slot_off,
    output logic [CW-1:0]             nwr,
    output logic [CW-1:0]             ndropped
);

    logic [CW-1:0] taken;

    // Walk lanes oldest first, handing out consecutive slots until space runs out.
    always_comb begin
        accept   = '0;
        slot_off = '0;
        ndropped = '0;
        taken    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cand[i]) begin
                if (CNT_BITS'(taken) < free) begin
                    accept[i]   = 1'b1;
                    slot_off[i] = taken;
                    taken       = taken + CW'(1);
                end else begin
                    ndropped = ndropped + CW'(1);
                end
            end
        end
        nwr = taken;
    end

endmodule

// File: rtl/el2_trace_buf.sv
// Multi-lane retire trace capture buffer: filters up to NUM_CH packets per
// cycle, stores them in a show-ahead FIFO, drains over valid/ready, flags the
// entry following any loss and keeps a saturating count of lost packets.
module el2_trace_buf
    import el2_trace_buf_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input logic           clk,
    input logic           rst,
    el2_trace_buf_if.slave bus
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CNT_BITS = AW + 1;
    localparam int CW       = $clog2(NUM_CH + 1);
    localparam int SW       = CNT_W + 1;

    el2_trace_entry_t mem [DEPTH];

    logic [AW-1:0]            rd_ptr;
    logic [AW-1:0]            wr_ptr;
    logic [CNT_BITS-1:0]      count;
    logic [CNT_BITS-1:0]      free;
    logic                     gap_pend;
    logic [CNT_W-1:0]         lost;
    logic [NUM_CH-1:0]        cand;
    logic [NUM_CH-1:0]        accept;
    logic [NUM_CH-1:0][CW-1:0] slot_off;
    logic [CW-1:0]            nwr;
    logic [CW-1:0]            ndropped;
    logic [CW-1:0]            drop_eff;
    logic [SW-1:0]            lost_sum;
    logic                     pop;

    // Qualify each lane against the current filter mode.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand[i] = lane_is_candidate(bus.trace_in[i], bus.tr_mode);
        end
    end

    // Space is judged before this cycle's pop, so a pop never makes room for a push.
    assign free = CNT_BITS'(DEPTH) - count;
    assign pop  = (count != '0) && bus.tr_out_ready;

    el2_trace_lane_sel #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) u_lane_sel (
        .cand     (cand),
        .free     (free),
        .accept   (accept),
        .slot_off (slot_off),
        .nwr      (nwr),
        .ndropped (ndropped)
    );

    // Store accepted lanes; only the first entry of a cycle carries the pending gap.
    always_ff @(posedge clk) begin
        if (!bus.tr_flush) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i]) begin
                    mem[wr_ptr + AW'(slot_off[i])] <= '{
                        gap: (slot_off[i] == '0) ? gap_pend : 1'b0,
                        pkt: bus.trace_in[i]
                    };
                end
            end
        end
    end

    // Pointers, occupancy and the gap flag; flush overrides push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            gap_pend <= 1'b0;
        end else if (bus.tr_flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            gap_pend <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(nwr);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CNT_BITS'(nwr) - CNT_BITS'(pop);
            if (ndropped != '0) begin
                gap_pend <= 1'b1;
            end else if (nwr != '0) begin
                gap_pend <= 1'b0;
            end
        end
    end

    // Inputs discarded by a flush are not losses.
    assign drop_eff = bus.tr_flush ? '0 : ndropped;
    assign lost_sum = {1'b0, lost} + SW'(drop_eff);

    // Saturating lost-packet counter; a clear still records this cycle's drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost <= '0;
        end else if (bus.tr_lost_clr) begin
            lost <= CNT_W'(drop_eff);
        end else if (lost_sum[CNT_W]) begin
            lost <= '1;
        end else begin
            lost <= lost_sum[CNT_W-1:0];
        end
    end

    assign bus.tr_out_valid = (count != '0);
    assign bus.tr_out_pkt   = bus.tr_out_valid ? mem[rd_ptr].pkt : '0;
    assign bus.tr_out_gap   = bus.tr_out_valid ? mem[rd_ptr].gap : 1'b0;
    assign bus.tr_count     = count;
    assign bus.tr_full      = (count == CNT_BITS'(DEPTH));
    assign bus.tr_lost_cnt  = lost;

endmodule

// File: tb/tb_el2_trace_buf.sv
// Self-checking bench for el2_trace_buf (NUM_CH=2, DEPTH=8). A reference
// model pushes expected entries into a queue as lanes are driven; each
// scenario task pops and compares them as the drain port delivers entries.
module tb_el2_trace_buf;
    import el2_trace_buf_pkg::*;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;
    localparam int CB     = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    el2_trace_entry_t exp_q[$];
    int               m_count;
    logic             m_gap;
    int               m_lost;

    logic             popped;
    el2_trace_entry_t got;
    el2_trace_entry_t want;

    always #5 clk = ~clk;

    el2_trace_buf_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    el2_trace_buf #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic el2_trace_pkt_t mk(input logic [31:0] insn, input logic exc,
                                          input logic intr, input logic [4:0] ecause);
        el2_trace_pkt_t p;
        p = '0;
        p.trace_rv_i_insn_ip      = insn;
        p.trace_rv_i_address_ip   = insn ^ 32'h8000_0000;
        p.trace_rv_i_valid_ip     = 1'b1;
        p.trace_rv_i_exception_ip = exc;
        p.trace_rv_i_interrupt_ip = intr;
        p.trace_rv_i_ecause_ip    = ecause;
        p.trace_rv_i_tval_ip      = {insn[15:0], insn[31:16]};
        return p;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_count = 0;
        m_gap   = 1'b0;
        m_lost  = 0;
    endfunction

    // One clock: drive lanes/controls, sample the head, advance the model, step to next negedge.
    task automatic cycle(input el2_trace_pkt_t p0, input el2_trace_pkt_t p1, input logic rdy,
                         input logic clr, input logic fl, output logic pop_o,
                         output el2_trace_entry_t got_o, output el2_trace_entry_t want_o);
        el2_trace_pkt_t lanes[2];
        int  nacc, ndrop, free;
        logic c;
        lanes[0] = p0;
        lanes[1] = p1;
        bus.trace_in[0]  = p0;
        bus.trace_in[1]  = p1;
        bus.tr_out_ready = rdy;
        bus.tr_lost_clr  = clr;
        bus.tr_flush     = fl;
        #1;
        got_o.gap = bus.tr_out_gap;
        got_o.pkt = bus.tr_out_pkt;
        pop_o  = 1'b0;
        want_o = '0;
        if (fl) begin
            exp_q.delete();
            m_count = 0;
            m_gap   = 1'b0;
            if (clr) m_lost = 0;
        end else begin
            free  = DEPTH - m_count;
            nacc  = 0;
            ndrop = 0;
            if (rdy && m_count > 0) begin
                pop_o = 1'b1;
                if (exp_q.size() > 0) want_o = exp_q.pop_front();
                m_count--;
            end
            for (int i = 0; i < 2; i++) begin
                c = lanes[i].trace_rv_i_valid_ip &&
                    (bus.tr_mode == TR_ALL ||
                     (bus.tr_mode == TR_EXC &&
                      (lanes[i].trace_rv_i_exception_ip || lanes[i].trace_rv_i_interrupt_ip)));
                if (c) begin
                    if (nacc < free) begin
                        exp_q.push_back('{gap: (nacc == 0) ? m_gap : 1'b0, pkt: lanes[i]});
                        nacc++;
                    end else begin
                        ndrop++;
                    end
                end
            end
            m_count += nacc;
            if (clr) m_lost = ndrop;
            else     m_lost = (m_lost + ndrop > 65535) ? 65535 : m_lost + ndrop;
            if (ndrop > 0)     m_gap = 1'b1;
            else if (nacc > 0) m_gap = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.trace_in     = '0;
        bus.tr_mode      = TR_ALL;
        bus.tr_flush     = 1'b0;
        bus.tr_lost_clr  = 1'b0;
        bus.tr_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.tr_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", bus.tr_out_valid); end
        checks++; if (bus.tr_out_gap !== 1'b0) begin errors++; $display("[TB] FAIL reset_gap got %0b want 0", bus.tr_out_gap); end
        checks++; if (bus.tr_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %0b want 0", bus.tr_full); end
        checks++; if (bus.tr_count !== CB'(0)) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", bus.tr_count); end
        checks++; if (bus.tr_lost_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_lost got %0d want 0", bus.tr_lost_cnt); end
        checks++; if (bus.tr_out_pkt !== '0) begin errors++; $display("[TB] FAIL reset_pkt got %h want 0", bus.tr_out_pkt); end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_basic();
        bus.tr_mode = TR_ALL;
        cycle(mk(32'h0000_0013, 0, 0, 0), mk(32'h0000_0093, 0, 0, 0), 1'b1, 1'b0, 1'b0, popped, got, want);
        checks++; if (bus.tr_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got %0b want 1", bus.tr_out_valid); end
        checks++; if (bus.tr_count !== CB'(2)) begin errors++; $display("[TB] FAIL basic_count got %0d want 2", bus.tr_count); end
        cycle('0, '0, 1'b1, 1'b0, 1'b0, popped, got, want);
        checks++; if (!popped || got.pkt.trace_rv_i_insn_ip !== 32'h13 || got !== want || got.gap !== 1'b0) begin errors++; $display("[TB] FAIL basic_first got %h want %h", got, want); end
        cycle('0, '0, 1'b1, 1'b0, 1'b0, popped, got, want);
        checks++; if (!popped || got.pkt.trace_rv_i_insn_ip !== 32'h93 || got !== want || got.gap !== 1'b0) begin errors++; $display("[TB] FAIL basic_second got %h want %h", got, want); end
        checks++; if (bus.tr_lost_cnt !== 16'd0) begin errors++; $display("[TB] FAIL basic_lost got %0d want 0", bus.tr_lost_cnt); end
        checks++; if (bus.tr_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_empty got %0b want 0", bus.tr_out_valid); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 3; k++)
            cycle(mk(32'h1000 + k * 8, 0, 0, 0), mk(32'h1004 + k * 8, 0, 0, 0), 1'b0, 1'b0, 1'b0, popped, got, want);
        cycle(mk(32'h1100, 0, 0, 0), '0, 1'b0, 1'b0, 1'b0, popped, got, want);
        checks++; if (bus.tr_count !== CB'(7) || bus.tr_full !== 1'b0) begin errors++; $display("[TB] FAIL ovf_count7 got %0d/%0b want 7/0", bus.tr_count, bus.tr_full); end
        cycle(mk(32'h1200, 0, 0, 0), mk(32'h1204, 0, 0, 0), 1'b0, 1'b0, 1'b0, popped, got, want);
        checks++; if (bus.tr_full !== 1'b1 || bus.tr_count !== CB'(8)) begin errors++; $display("[TB] FAIL ovf_full got %0b/%0d want 1/8", bus.tr_full, bus.tr_count); end
        checks++; if (bus.tr_lost_cnt !== 16'd1) begin errors++; $display("[TB] FAIL ovf_lost got %0d want 1", bus.tr_lost_cnt); end
        for (int k = 0; k < 8; k++) begin
            cycle('0, '0, 1'b1, 1'b0, 1'b0, popped, got, want);
            checks++; if (!popped || got !== want) begin errors++; $display("[TB] FAIL ovf_drain%0d got %h want %h", k, got, want); end
        end
        checks++; if (want.pkt.trace_rv_i_insn_ip !== 32'h1200) begin errors++; $display("[TB] FAIL ovf_last_stored got %h want 1200", want.pkt.trace_rv_i_insn_ip); end
        cycle(mk(32'h1300, 0, 0, 0), '0, 1'b1, 1'b0, 1'b0, popped, got, want);
        cycle(mk(32'h1400, 0, 0, 0), '0, 1'b1, 1'b0, 1'b0, popped, got, want);
        checks++; if (!popped || got.gap !== 1'b1 || got.pkt.trace_rv_i_insn_ip !== 32'h1300 || got !== want) begin errors++; $display("[TB] FAIL ovf_gap_set got %h want %h", got, want); end
        cycle('0, '0, 1'b1, 1'b0, 1'b0, popped, got, want);
        checks++; if (!popped || got.gap !== 1'b0 || got.pkt.trace_rv_i_insn_ip !== 32'h1400 || got !== want) begin errors++; $display("[TB] FAIL ovf_gap_clr got %h want %h", got, want); end
    endtask

    task automatic test_exc_only();
        bus.tr_mode = TR_EXC;
        cycle(mk(32'h2000, 0, 0, 0), mk(32'h2004, 1, 0, 5'd2), 1'b0, 1'b0, 1'b0, popped, got, want);
        checks++; if (bus.tr_count !== CB'(1)) begin errors++; $display("[TB] FAIL exc_count got %0d want 1", bus.tr_count); end
        checks++; if (bus.tr_lost_cnt !== 16'd1) begin errors++; $display("[TB] FAIL exc_lost got %0d want 1", bus.tr_lost_cnt); end
        cycle('0, '0, 1'b1, 1'b0, 1'b0, popped, got, want);
        checks++; if (!popped || got.pkt.trace_rv_i_insn_ip !== 32'h2004 || got.pkt.trace_rv_i_ecause_ip !== 5'd2 || got !== want) begin errors++; $display("[TB] FAIL exc_pkt got %h want %h", got, want); end
        cycle(mk(32'h2100, 0, 1, 0), mk(32'h2104, 0, 0, 0), 1'b0, 1'b0, 1'b0, popped, got, want);
        cycle('0, '0, 1'b1, 1'b0, 1'b0, popped, got, want);
        checks++; if (!popped || got.pkt.trace_rv_i_insn_ip !== 32'h2100 || got !== want) begin errors++; $display("[TB] FAIL exc_intr got %h want %h", got, want); end
        bus.tr_mode = TR_OFF0;
        cycle(mk(32'h2200, 1, 0, 1), mk(32'h2204, 0, 0, 0), 1'b0, 1'b0, 1'b0, popped, got, want);
        bus.tr_mode = TR_OFF1;
        cycle(mk(32'h2300, 0, 1, 0), mk(32'h2304, 0, 0, 0), 1'b0, 1'b0, 1'b0, popped, got, want);
        checks++; if (bus.tr_count !== CB'(0) || bus.tr_lost_cnt !== 16'd1) begin errors++; $display("[TB] FAIL off_mode got count %0d lost %0d want 0/1", bus.tr_count, bus.tr_lost_cnt); end
        bus.tr_mode = TR_ALL;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 20; k++) begin
            cycle(mk($urandom, 0, 0, 0), '0, 1'b1, 1'b0, 1'b0, popped, got, want);
            if (k > 0) begin
                checks++; if (!popped || got !== want) begin errors++; $display("[TB] FAIL b2b_%0d got %h want %h", k, got, want); end
            end
        end
        cycle('0, '0, 1'b1, 1'b0, 1'b0, popped, got, want);
        checks++; if (!popped || got !== want) begin errors++; $display("[TB] FAIL b2b_tail got %h want %h", got, want); end
        for (int k = 0; k < 4; k++)
            cycle(mk($urandom, 0, 0, 0), mk($urandom, 0, 0, 0), 1'b0, 1'b0, 1'b0, popped, got, want);
        cycle(mk(32'h3000, 0, 0, 0), mk(32'h3004, 0, 0, 0), 1'b1, 1'b0, 1'b0, popped, got, want);
        checks++; if (!popped || got !== want) begin errors++; $display("[TB] FAIL fullpop_head got %h want %h", got, want); end
        checks++; if (bus.tr_count !== CB'(7) || bus.tr_lost_cnt !== 16'd3) begin errors++; $display("[TB] FAIL fullpop_reject got count %0d lost %0d want 7/3", bus.tr_count, bus.tr_lost_cnt); end
        for (int k = 0; k < 7; k++) begin
            cycle('0, '0, 1'b1, 1'b0, 1'b0, popped, got, want);
            checks++; if (!popped || got !== want) begin errors++; $display("[TB] FAIL fullpop_drain%0d got %h want %h", k, got, want); end
        end
    endtask

    task automatic test_lost_sat();
        cycle('0, '0, 1'b0, 1'b1, 1'b0, popped, got, want);
        checks++; if (bus.tr_lost_cnt !== 16'd0) begin errors++; $display("[TB] FAIL sat_clr got %0d want 0", bus.tr_lost_cnt); end
        for (int k = 0; k < DEPTH && m_count < DEPTH; k++)
            cycle(mk(32'h4000 + k * 8, 0, 0, 0), mk(32'h4004 + k * 8, 0, 0, 0), 1'b0, 1'b0, 1'b0, popped, got, want);
        for (int k = 0; k < 32767; k++)
            cycle(mk(32'h5000, 0, 0, 0), mk(32'h5004, 0, 0, 0), 1'b0, 1'b0, 1'b0, popped, got, want);
        checks++; if (bus.tr_lost_cnt !== 16'hFFFE) begin errors++; $display("[TB] FAIL sat_fffe got %h want fffe", bus.tr_lost_cnt); end
        cycle(mk(32'h5100, 0, 0, 0), mk(32'h5104, 0, 0, 0), 1'b0, 1'b0, 1'b0, popped, got, want);
        checks++; if (bus.tr_lost_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_ffff got %h want ffff", bus.tr_lost_cnt); end
        cycle(mk(32'h5200, 0, 0, 0), mk(32'h5204, 0, 0, 0), 1'b0, 1'b0, 1'b0, popped, got, want);
        checks++; if (bus.tr_lost_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_hold got %h want ffff", bus.tr_lost_cnt); end
        cycle(mk(32'h5300, 0, 0, 0), '0, 1'b0, 1'b1, 1'b0, popped, got, want);
        checks++; if (bus.tr_lost_cnt !== 16'd1 || bus.tr_lost_cnt !== CNT_W'(m_lost)) begin errors++; $display("[TB] FAIL sat_clr_drop got %0d want 1", bus.tr_lost_cnt); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            cycle('0, '0, 1'b1, 1'b0, 1'b0, popped, got, want);
            checks++; if (!popped || got !== want) begin errors++; $display("[TB] FAIL flush_pre%0d got %h want %h", k, got, want); end
        end
        checks++; if (bus.tr_count !== CB'(5)) begin errors++; $display("[TB] FAIL flush_count5 got %0d want 5", bus.tr_count); end
        cycle(mk(32'h6000, 0, 0, 0), mk(32'h6004, 0, 0, 0), 1'b1, 1'b0, 1'b1, popped, got, want);
        checks++; if (bus.tr_count !== CB'(0) || bus.tr_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty got count %0d valid %0b want 0/0", bus.tr_count, bus.tr_out_valid); end
        checks++; if (bus.tr_lost_cnt !== 16'd1) begin errors++; $display("[TB] FAIL flush_lost got %0d want 1", bus.tr_lost_cnt); end
        cycle(mk(32'h6100, 0, 0, 0), '0, 1'b1, 1'b0, 1'b0, popped, got, want);
        cycle('0, '0, 1'b1, 1'b0, 1'b0, popped, got, want);
        checks++; if (!popped || got.gap !== 1'b0 || got.pkt.trace_rv_i_insn_ip !== 32'h6100 || got !== want) begin errors++; $display("[TB] FAIL flush_gap got %h want %h", got, want); end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++)
            cycle(mk(32'h7000 + k * 8, 0, 0, 0), mk(32'h7004 + k * 8, 0, 0, 0), 1'b0, 1'b0, 1'b0, popped, got, want);
        checks++; if (bus.tr_count !== CB'(4)) begin errors++; $display("[TB] FAIL arst_pre got %0d want 4", bus.tr_count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.tr_out_valid !== 1'b0 || bus.tr_count !== CB'(0) || bus.tr_lost_cnt !== 16'd0) begin errors++; $display("[TB] FAIL arst_now got valid %0b count %0d lost %0d want 0/0/0", bus.tr_out_valid, bus.tr_count, bus.tr_lost_cnt); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(mk(32'h7100, 0, 0, 0), '0, 1'b1, 1'b0, 1'b0, popped, got, want);
        cycle('0, '0, 1'b1, 1'b0, 1'b0, popped, got, want);
        checks++; if (!popped || got.pkt.trace_rv_i_insn_ip !== 32'h7100 || got !== want) begin errors++; $display("[TB] FAIL arst_after got %h want %h", got, want); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_exc_only();
        test_back_to_back();
        test_lost_sat();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
